// File: rtl/jfpjc_pkg.sv
// Shared definitions for the JPEG strip readout path: MCU geometry, scheduler
// states and EBR address split helpers.
package jfpjc_pkg;

  localparam int unsigned MCU_PIX = 64;
  localparam int unsigned MCU_DIM = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } sched_state_t;

  // Low address bits: pixel offset inside one MCU, row-major.
  function automatic logic [5:0] mcu_offset(input logic [2:0] py, input logic [2:0] px);
    return {py, px};
  endfunction

  // Upper address bits left for the per-EBR MCU slot index.
  function automatic int unsigned ebr_hi_width(input int unsigned ebr_size);
    return $clog2(ebr_size) - $clog2(MCU_PIX);
  endfunction

endpackage

// File: rtl/mcu_strip_scheduler_addr_walker.sv
// MCU address walker: px/py/mcu ripple counters, with EBR block and slot
// tracked by wrap counters so no divider is needed.
module mcu_addr_walker
  import jfpjc_pkg::*;
#(
  parameter int unsigned mcus     = 40,
  parameter int unsigned num_ebr  = 5,
  parameter int unsigned ebr_size = 512
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        advance,
  input  logic                        clear,
  output logic [$clog2(num_ebr)-1:0]  block,
  output logic [$clog2(ebr_size)-1:0] addr,
  output logic                        first,
  output logic                        mcu_end,
  output logic                        last
);

  localparam int unsigned MCU_W = $clog2(mcus);
  localparam int unsigned BLK_W = $clog2(num_ebr);
  localparam int unsigned HI_W  = ebr_hi_width(ebr_size);
  localparam logic [MCU_W-1:0] MCU_MAX = MCU_W'(mcus - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(num_ebr - 1);

  logic [2:0]       px;
  logic [2:0]       py;
  logic [MCU_W-1:0] mcu;
  logic [HI_W-1:0]  hi;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      px    <= '0;
      py    <= '0;
      mcu   <= '0;
      block <= '0;
      hi    <= '0;
    end else if (clear) begin
      px    <= '0;
      py    <= '0;
      mcu   <= '0;
      block <= '0;
      hi    <= '0;
    end else if (advance) begin
      px <= px + 3'd1;
      if (px == 3'd7) begin
        py <= py + 3'd1;
        if (py == 3'd7) begin
          if (mcu == MCU_MAX) begin
            mcu   <= '0;
            block <= '0;
            hi    <= '0;
          end else begin
            mcu <= mcu + MCU_W'(1);
            // block = mcu % num_ebr, hi = mcu / num_ebr, stepped together
            if (block == BLK_MAX) begin
              block <= '0;
              hi    <= hi + HI_W'(1);
            end else begin
              block <= block + BLK_W'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    addr    = {hi, mcu_offset(py, px)};
    first   = (px == 3'd0) && (py == 3'd0);
    mcu_end = (px == 3'd7) && (py == 3'd7);
    last    = mcu_end && (mcu == MCU_MAX);
  end

endmodule

// File: rtl/mcu_strip_scheduler.sv
// Double-buffered strip readout scheduler between the HM01B0 ingester/EBR bank
// and the JPEG pipeline. Optional MCU_SCHED_OVERRUN_CNT_EN adds overrun_count.
module mcu_strip_scheduler
  import jfpjc_pkg::*;
#(
  parameter int unsigned width_pix  = 320,
  parameter int unsigned height_pix = 240,
  parameter int unsigned num_ebr    = 5,
  parameter int unsigned ebr_size   = 512
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        ing_frontbuffer,
  output logic                        rd_buffer,
  output logic [$clog2(num_ebr)-1:0]  rd_block_select,
  output logic [$clog2(ebr_size)-1:0] rd_addr,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic                        pix_valid,
  output logic                        pix_mcu_first,
  output logic                        pix_mcu_last,
  output logic                        strip_done,
  output logic                        frame_done,
  output logic                        overrun
`ifdef MCU_SCHED_OVERRUN_CNT_EN
  ,
  output logic [15:0]                 overrun_count
`endif
);

  localparam int unsigned MCUS    = width_pix / MCU_DIM;
  localparam int unsigned STRIPS  = height_pix / MCU_DIM;
  localparam int unsigned STRIP_W = $clog2(STRIPS);
  localparam logic [STRIP_W-1:0] STRIP_MAX = STRIP_W'(STRIPS - 1);

  sched_state_t       state;
  logic [1:0]         full;
  logic [1:0]         full_nxt;
  logic               prev_fb;
  logic               toggle;
  logic               ovr_evt;
  logic               accept;
  logic               release_now;
  logic               walk_first;
  logic               walk_mcu_end;
  logic               walk_last;
  logic [STRIP_W-1:0] strip;

  mcu_addr_walker #(
    .mcus    (MCUS),
    .num_ebr (num_ebr),
    .ebr_size(ebr_size)
  ) u_walker (
    .clock  (clock),
    .nreset (nreset),
    .advance(accept),
    .clear  (release_now),
    .block  (rd_block_select),
    .addr   (rd_addr),
    .first  (walk_first),
    .mcu_end(walk_mcu_end),
    .last   (walk_last)
  );

  // A toggle marks half prev_fb full; if that half is still full (unread, or
  // being released this very cycle) the ingester overwrote it: overrun.
  always_comb begin
    toggle      = ing_frontbuffer != prev_fb;
    accept      = rd_valid && rd_ready;
    release_now = state == RELEASE;
    ovr_evt     = toggle && full[prev_fb];
    full_nxt    = full;
    if (release_now) full_nxt[rd_buffer] = 1'b0;
    if (toggle)      full_nxt[prev_fb]   = 1'b1;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      rd_valid   <= 1'b0;
      rd_buffer  <= 1'b0;
      strip      <= '0;
      strip_done <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      strip_done <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (full[rd_buffer]) begin
            state    <= ISSUE;
            rd_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (accept && walk_last) begin
            state      <= RELEASE;
            rd_valid   <= 1'b0;
            strip_done <= 1'b1;
            frame_done <= strip == STRIP_MAX;
          end
        end
        RELEASE: begin
          rd_buffer <= ~rd_buffer;
          strip     <= (strip == STRIP_MAX) ? '0 : strip + STRIP_W'(1);
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      prev_fb       <= 1'b0;
      full          <= '0;
      overrun       <= 1'b0;
      pix_valid     <= 1'b0;
      pix_mcu_first <= 1'b0;
      pix_mcu_last  <= 1'b0;
    end else begin
      prev_fb       <= ing_frontbuffer;
      full          <= full_nxt;
      if (ovr_evt) overrun <= 1'b1;
      pix_valid     <= accept;
      pix_mcu_first <= accept && walk_first;
      pix_mcu_last  <= accept && walk_mcu_end;
    end
  end

`ifdef MCU_SCHED_OVERRUN_CNT_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      overrun_count <= '0;
    end else if (ovr_evt && (overrun_count != '1)) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mcu_strip_scheduler.sv
// Randomized bench for mcu_strip_scheduler against a beat-level reference model
// of the strip buffers, address order and pulse outputs.
module tb_mcu_strip_scheduler;

  localparam int MCUS   = 40;
  localparam int NEBR   = 5;
  localparam int BEATS  = MCUS * 64;
  localparam int STRIPS = 30;

  logic        clock;
  logic        nreset;
  logic        ing_frontbuffer;
  logic        rd_buffer;
  logic [2:0]  rd_block_select;
  logic [8:0]  rd_addr;
  logic        rd_valid;
  logic        rd_ready;
  logic        pix_valid;
  logic        pix_mcu_first;
  logic        pix_mcu_last;
  logic        strip_done;
  logic        frame_done;
  logic        overrun;
`ifdef MCU_SCHED_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  mcu_strip_scheduler #(
    .width_pix (320),
    .height_pix(240),
    .num_ebr   (NEBR),
    .ebr_size  (512)
  ) dut (
    .clock          (clock),
    .nreset         (nreset),
    .ing_frontbuffer(ing_frontbuffer),
    .rd_buffer      (rd_buffer),
    .rd_block_select(rd_block_select),
    .rd_addr        (rd_addr),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .pix_valid      (pix_valid),
    .pix_mcu_first  (pix_mcu_first),
    .pix_mcu_last   (pix_mcu_last),
    .strip_done     (strip_done),
    .frame_done     (frame_done),
    .overrun        (overrun)
`ifdef MCU_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_count  (overrun_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, describing the DUT as it will be after the next posedge.
  logic [1:0] mfull;
  logic       mrdbuf;
  logic       movr;
  int         mcnt;
  int         k;
  int         mstrip;
  logic       prev_acc;
  logic       prev_first;
  logic       prev_last;
  logic       prev_done;
  int         pixcnt;
  int         idle_wait;
  int         feed_left;
  int         strips_model;
  int         dut_strips;
  int         frames_done;
  int         guard;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int beat, input logic half);
    int mcu;
    int py;
    int px;
    mcu = beat / 64;
    py  = (beat % 64) / 8;
    px  = beat % 8;
    return int'(half) * 4096 + (mcu % NEBR) * 512 + (mcu / NEBR) * 64 + py * 8 + px;
  endfunction

  function automatic int out_vec();
    return int'({rd_buffer, rd_block_select, rd_addr, rd_valid, pix_valid, pix_mcu_first,
                 pix_mcu_last, strip_done, frame_done, overrun});
  endfunction

  task automatic model_reset();
    mfull      = '0;
    mrdbuf     = 1'b0;
    movr       = 1'b0;
    mcnt       = 0;
    k          = 0;
    mstrip     = 0;
    prev_acc   = 1'b0;
    prev_first = 1'b0;
    prev_last  = 1'b0;
    prev_done  = 1'b0;
    pixcnt     = 0;
    idle_wait  = 0;
    feed_left  = 0;
  endtask

  // One cycle: check outputs at negedge, then drive inputs and advance the model
  // to what the coming posedge should produce.
  task automatic tick(input logic rdy, input logic tog);
    logic do_tog;
    logic half;
    logic acc;
    logic rel;
    @(negedge clock);
    if (rd_valid)
      check_eq("addr", int'(rd_buffer) * 4096 + int'(rd_block_select) * 512 + int'(rd_addr),
               exp_addr(k, mrdbuf));
    check_eq("valid_when_empty", int'(rd_valid && !mfull[mrdbuf]), 0);
    rel = prev_done;
    if (!rd_valid && mfull[mrdbuf] && !rel) idle_wait++;
    else idle_wait = 0;
    check_eq("valid_latency", int'(idle_wait > 2), 0);
    check_eq("pix_flags", int'({pix_valid, pix_mcu_first, pix_mcu_last}),
             int'({prev_acc, prev_first, prev_last}));
    check_eq("done_pulses", int'({strip_done, frame_done}),
             int'({rel, rel && (mstrip == STRIPS - 1)}));
    check_eq("overrun", int'(overrun), int'(movr));
`ifdef MCU_SCHED_OVERRUN_CNT_EN
    check_eq("overrun_count", int'(overrun_count), mcnt);
`endif
    if (pix_valid) pixcnt++;
    if (strip_done) begin
      check_eq("pix_count", pixcnt, BEATS);
      pixcnt = 0;
      dut_strips++;
      if (frame_done) frames_done++;
    end

    do_tog = tog;
    if (!tog && rel && feed_left > 0) begin
      do_tog = 1'b1;
      feed_left--;
    end
    half = ing_frontbuffer;
    acc  = rd_valid && rdy;
    if (do_tog && mfull[half]) begin
      movr = 1'b1;
      if (mcnt < 65535) mcnt++;
    end
    if (rel) begin
      mfull[mrdbuf] = 1'b0;
      mrdbuf        = !mrdbuf;
      k             = 0;
      mstrip        = (mstrip == STRIPS - 1) ? 0 : mstrip + 1;
      strips_model++;
    end
    if (do_tog) mfull[half] = 1'b1;
    prev_acc   = acc;
    prev_first = acc && (k % 64 == 0);
    prev_last  = acc && (k % 64 == 63);
    if (acc) k++;
    prev_done  = acc && (k == BEATS);
    rd_ready = rdy;
    if (do_tog) ing_frontbuffer = !ing_frontbuffer;
  endtask

  initial begin
    nreset          = 1'b0;
    ing_frontbuffer = 1'b0;
    rd_ready        = 1'b0;
    strips_model    = 0;
    dut_strips      = 0;
    frames_done     = 0;
    model_reset();
    @(negedge clock);
    check_eq("reset_outputs", out_vec(), 0);
`ifdef MCU_SCHED_OVERRUN_CNT_EN
    check_eq("reset_overrun_count", int'(overrun_count), 0);
`endif
    @(negedge clock);
    nreset = 1'b1;

    // One frame: each further strip is handed over in the RELEASE cycle of the other half.
    feed_left = STRIPS - 1;
    tick(1'b1, 1'b1);
    guard = 0;
    while (strips_model < STRIPS && guard < 90000) begin
      tick((strips_model == 1) ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
      guard++;
    end
    check_eq("strips_read", dut_strips, STRIPS);
    check_eq("frame_done_count", frames_done, 1);
    repeat (4) tick(1'b1, 1'b0);

    // Overrun: third handover lands on a half that was never read.
    tick(1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    check_eq("overrun_two_toggles", int'(overrun), 0);
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    check_eq("overrun_third_toggle", int'(overrun), 1);
`ifdef MCU_SCHED_OVERRUN_CNT_EN
    check_eq("overrun_count_one", int'(overrun_count), 1);
`endif
    repeat (50) tick(1'b1, 1'b0);
    check_eq("mid_issue_valid", int'(rd_valid), 1);

    // Asynchronous reset in the middle of a strip.
    #2 nreset = 1'b0;
    #1 check_eq("async_reset_outputs", out_vec(), 0);
`ifdef MCU_SCHED_OVERRUN_CNT_EN
    check_eq("async_reset_overrun_count", int'(overrun_count), 0);
`endif
    ing_frontbuffer = 1'b0;
    rd_ready        = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    nreset = 1'b1;
    repeat (20) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (150) tick(1'($urandom_range(0, 1)), 1'b0);
    check_eq("resume_after_reset", int'(k > 0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
